alu_issue_arbiter: RTL and testbench
====================================

Name: alu_issue_arbiter

Overview:
Shares the single 16-bit ALU between NUM_REQ requesters, for example the execute stage and an address/PC helper.
- Round-robin arbitration with valid/ready handshakes.
- Drives the ALU operand and opcode inputs combinationally from the granted request.
- Registers the ALU result in a one-entry output buffer with backpressure.
- Owns the architectural Z/V/N flag register and updates it selectively per opcode.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ID_W, 1, width of res_id; must satisfy 2**ID_W >= NUM_REQ
DATA_W, 16, operand/result width; fixed at 16 to match ALU

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operation valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_opcode  in  3*NUM_REQ  packed opcodes; requester i at [3i+2:3i]
req_a  in  16*NUM_REQ  packed operand A
req_b  in  16*NUM_REQ  packed operand B
alu_in1  out  16  to ALU operand 1
alu_in2  out  16  to ALU operand 2
alu_opcode  out  3  to ALU opcode
alu_out  in  16  ALU result
alu_error  in  1  ALU overflow/error
res_valid  out  1  result buffer full
res_ready  in  1  consumer accepts result
res_data  out  16  buffered result
res_id  out  ID_W  index of requester that issued result
res_err  out  1  buffered alu_error
flags  out  3  flag register {Z,V,N}; Z=bit2, V=bit1, N=bit0

Behaviour:
- Reset (async, rst_n=0):
  - res_valid=0, res_data=0, res_id=0, res_err=0, flags=3'b000, rr_ptr=0.
  - Any held result is discarded.
- Two-state FSM:
  - EMPTY: buffer free.
  - FULL: res_valid=1.
- can_issue = (state==EMPTY) || res_ready.
  - Gives bubble-free throughput of 1 op/cycle while res_ready=1.
- Grant:
  - First i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[grant]=can_issue; all other req_ready bits are 0.
  - No valid request means no grant and req_ready=0.
- ALU drive is combinational from the granted request: alu_in1=req_a, alu_in2=req_b, alu_opcode=req_opcode.
  - With no grant, drive 0/0/3'b000.
- Issue handshake: req_valid[g] && req_ready[g]. At that clock edge:
  - res_data<=alu_out, res_err<=alu_error, res_id<=g, state<=FULL.
  - rr_ptr<=(g+1) mod NUM_REQ.
  - The flag register is updated in the same edge.
- Result latency: 1 cycle from issue to res_valid.
- Result hold: res_data, res_id and res_err stay stable while res_valid && !res_ready.
- Drain:
  - res_valid && res_ready with no new issue: state<=EMPTY.
  - Drain and issue in the same cycle: state stays FULL with the new contents.
- Flag update mask, computed from the issued opcode and alu_out/alu_error:
  - 000 ADD, 001 SUB: Z=(alu_out==0), V=alu_error, N=alu_out[15].
  - 010 XOR, 100 SLL, 101 SRA, 110 ROR: Z only; V and N retained.
  - 011 RED, 111 PADSUB: no flag change.
- Flags never change without an issue handshake.
- Requester protocol:
  - Requesters hold valid/opcode/operands stable until ready.
  - A drop of req_valid before ready is tolerated; no state effect.
- rr_ptr is not advanced when there is no issue.

Optional Feature:
ALU_ERR_STICKY_EN
- Enabled: adds input err_clr (1 bit) and output err_sticky (1 bit).
  - err_sticky sets on any issue with alu_error=1.
  - It clears on err_clr; set wins over clear in the same cycle.
  - Reset value is 0.
- Disabled: the ports are absent and there is no sticky state; all other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - Opcode enum (ADD, SUB, XOR, RED, SLL, SRA, ROR, PADSUB).
  - Flag index constants (FLAG_Z=2, FLAG_V=1, FLAG_N=0).
  - 3-bit flag-update-mask function keyed by opcode.
- Sub-module rr_arbiter: NUM_REQ-wide round-robin grant with pointer and advance enable, reusable for other shared units.

Test Plan:
- Req0 issues ADD 0x7FFF+0x0001 with res_ready=1:
  - next cycle res_data=0x8000, res_err=1, res_id=0, flags=3'b011.
- After the ADD above, req1 issues XOR 0x00FF^0x00FF:
  - res_data=0x0000, flags=3'b111 (Z set, V/N retained).
  - Then RED on any operands: flags stay 3'b111.
- Both req_valid held high, res_ready=1, 6 cycles:
  - grants alternate 0,1,0,1,0,1; res_id follows one cycle later with no bubbles.
- res_ready=0 for 3 cycles after an issue of SUB 5-5:
  - res_data=0, res_valid=1 held; req_ready=2'b00 throughout; flags=3'b100 unchanged.
  - Raising res_ready re-enables issue in the same cycle.
- Assert rst_n=0 mid-FULL:
  - res_valid, flags and res_data read 0 immediately (async).
  - First grant after release goes to req0.
- With ALU_ERR_STICKY_EN:
  - Overflowing ADD, then a clean SUB: err_sticky stays 1.
  - err_clr pulse clears it; err_clr coincident with an overflow leaves it 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: opcode encoding, flag bit
// positions and the per-opcode flag update mask.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_XOR    = 3'b010,
        OP_RED    = 3'b011,
        OP_SLL    = 3'b100,
        OP_SRA    = 3'b101,
        OP_ROR    = 3'b110,
        OP_PADSUB = 3'b111
    } alu_op_e;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // Which of {Z,V,N} an opcode is allowed to write; cleared bits keep
    // their previous value.
    function automatic logic [2:0] flag_mask(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB:                 flag_mask = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_mask = 3'b100;
            default:                        flag_mask = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter. Search starts at the stored pointer and the
// pointer moves past the winner only when the caller signals an accepted
// grant, so a stalled or withdrawn request never costs anyone its turn.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               adv_en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand;

    // Scan from farthest to nearest offset so the nearest valid request wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // One-hot view of the winning index.
    always_comb begin
        gnt = '0;
        if (gnt_vld) gnt[gnt_idx] = 1'b1;
    end

    // Pointer moves to the slot after the accepted winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_q <= '0;
        else if (adv_en && gnt_vld)
            ptr_q <= IDX_W'((int'(gnt_idx) + 1) % NUM_REQ);
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one 16-bit ALU between NUM_REQ requesters. The granted request
// drives the ALU combinationally, the result lands in a one-entry output
// buffer, and the Z/V/N flag register is updated per opcode on issue.
// Optional: define ALU_ERR_STICKY_EN to add err_clr / err_sticky.
module alu_issue_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1,
    parameter int DATA_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef ALU_ERR_STICKY_EN
    input  logic                    err_clr,
    output logic                    err_sticky,
`endif
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [3*NUM_REQ-1:0]    req_opcode,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic [DATA_W-1:0]       alu_in1,
    output logic [DATA_W-1:0]       alu_in2,
    output logic [2:0]              alu_opcode,
    input  logic [DATA_W-1:0]       alu_out,
    input  logic                    alu_error,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_W-1:0]       res_data,
    output logic [ID_W-1:0]         res_id,
    output logic                    res_err,
    output logic [2:0]              flags
);

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

    state_e                           state;
    logic                             can_issue;
    logic                             issue;
    logic [NUM_REQ-1:0]               gnt;
    logic [ID_W-1:0]                  gnt_idx;
    logic                             gnt_vld;
    logic [NUM_REQ-1:0][2:0]          op_arr;
    logic [NUM_REQ-1:0][DATA_W-1:0]   a_arr;
    logic [NUM_REQ-1:0][DATA_W-1:0]   b_arr;
    logic [2:0]                       mask;
    logic [2:0]                       flags_nxt;

    assign op_arr = req_opcode;
    assign a_arr  = req_a;
    assign b_arr  = req_b;

    // The buffer can take a new result when empty or when it drains this cycle.
    assign can_issue = (state == ST_EMPTY) || res_ready;
    assign issue     = gnt_vld && can_issue;
    assign req_ready = gnt & {NUM_REQ{can_issue}};
    assign res_valid = (state == ST_FULL);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .adv_en  (can_issue),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Steer the granted request onto the ALU; idle inputs are zero.
    always_comb begin
        alu_in1    = '0;
        alu_in2    = '0;
        alu_opcode = 3'b000;
        if (gnt_vld) begin
            alu_in1    = a_arr[gnt_idx];
            alu_in2    = b_arr[gnt_idx];
            alu_opcode = op_arr[gnt_idx];
        end
    end

    // Next flag value: masked bits take the new result, others are retained.
    always_comb begin
        mask      = flag_mask(alu_opcode);
        flags_nxt = flags;
        if (mask[FLAG_Z]) flags_nxt[FLAG_Z] = (alu_out == '0);
        if (mask[FLAG_V]) flags_nxt[FLAG_V] = alu_error;
        if (mask[FLAG_N]) flags_nxt[FLAG_N] = alu_out[DATA_W-1];
    end

    // Result buffer FSM: an issue always (re)fills, a drain without issue empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            res_data <= '0;
            res_id   <= '0;
            res_err  <= 1'b0;
        end else if (issue) begin
            state    <= ST_FULL;
            res_data <= alu_out;
            res_id   <= gnt_idx;
            res_err  <= alu_error;
        end else if (state == ST_FULL && res_ready) begin
            state    <= ST_EMPTY;
        end
    end

    // Architectural flags change only on an issue handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flags <= 3'b000;
        else if (issue)
            flags <= flags_nxt;
    end

`ifdef ALU_ERR_STICKY_EN
    // Sticky error: a new error outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_sticky <= 1'b0;
        else if (issue && alu_error)
            err_sticky <= 1'b1;
        else if (err_clr)
            err_sticky <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with a small behavioural ALU.
// Build with ALU_ERR_STICKY_EN defined to also exercise the sticky error.
module tb_alu_issue_arbiter;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][2:0]   op;
    logic [1:0][15:0]  a;
    logic [1:0][15:0]  b;
    logic [15:0]       alu_in1, alu_in2, alu_out;
    logic [2:0]        alu_opcode;
    logic              alu_error;
    logic              res_valid, res_ready, res_err;
    logic [15:0]       res_data;
    logic [0:0]        res_id;
    logic [2:0]        flags;
`ifdef ALU_ERR_STICKY_EN
    logic              err_clr;
    logic              err_sticky;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.NUM_REQ(2), .ID_W(1), .DATA_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef ALU_ERR_STICKY_EN
        .err_clr    (err_clr),
        .err_sticky (err_sticky),
`endif
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (op),
        .req_a      (a),
        .req_b      (b),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_opcode (alu_opcode),
        .alu_out    (alu_out),
        .alu_error  (alu_error),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_err    (res_err),
        .flags      (flags)
    );

    // Behavioural ALU: error flags signed overflow on ADD/SUB only.
    always_comb begin
        alu_out   = 16'h0000;
        alu_error = 1'b0;
        case (alu_opcode)
            3'b000: begin
                alu_out   = alu_in1 + alu_in2;
                alu_error = (alu_in1[15] == alu_in2[15]) && (alu_out[15] != alu_in1[15]);
            end
            3'b001: begin
                alu_out   = alu_in1 - alu_in2;
                alu_error = (alu_in1[15] != alu_in2[15]) && (alu_out[15] != alu_in1[15]);
            end
            3'b010: alu_out = alu_in1 ^ alu_in2;
            3'b011: alu_out = {15'h0000, ^alu_in1};
            3'b100: alu_out = alu_in1 << alu_in2[3:0];
            3'b101: alu_out = $signed(alu_in1) >>> alu_in2[3:0];
            3'b110: alu_out = (alu_in1 >> alu_in2[3:0]) | (alu_in1 << (5'd16 - {1'b0, alu_in2[3:0]}));
            default: alu_out = alu_in1 - alu_in2;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change here, checks follow #1.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        op        = '0;
        a         = '0;
        b         = '0;
        res_ready = 1'b1;
`ifdef ALU_ERR_STICKY_EN
        err_clr   = 1'b0;
`endif
        #12;
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data",  32'(res_data),  32'd0);
        chk("rst_flags", 32'(flags),     32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("idle_alu",  {alu_in1, alu_in2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ADD overflow from req0
        req_valid = 2'b01; op[0] = 3'b000; a[0] = 16'h7FFF; b[0] = 16'h0001;
        #1;
        chk("add_ready", 32'(req_ready), 32'd1);
        chk("add_in1",   32'(alu_in1),   32'h7FFF);
        chk("add_in2",   32'(alu_in2),   32'h0001);
        chk("add_op",    32'(alu_opcode), 32'd0);
        step();
        req_valid = 2'b00;
        chk("add_valid", 32'(res_valid), 32'd1);
        chk("add_data",  32'(res_data),  32'h8000);
        chk("add_err",   32'(res_err),   32'd1);
        chk("add_id",    32'(res_id),    32'd0);
        chk("add_flags", 32'(flags),     32'b011);

        // XOR to zero from req1: Z set, V/N retained
        req_valid = 2'b10; op[1] = 3'b010; a[1] = 16'h00FF; b[1] = 16'h00FF;
        #1;
        chk("xor_ready", 32'(req_ready), 32'd2);
        step();
        req_valid = 2'b00;
        chk("xor_data",  32'(res_data), 32'h0000);
        chk("xor_id",    32'(res_id),   32'd1);
        chk("xor_err",   32'(res_err),  32'd0);
        chk("xor_flags", 32'(flags),    32'b111);

        // RED leaves flags alone
        req_valid = 2'b01; op[0] = 3'b011; a[0] = 16'h1234; b[0] = 16'h5678;
        step();
        req_valid = 2'b00;
        chk("red_id",    32'(res_id), 32'd0);
        chk("red_flags", 32'(flags),  32'b111);

        // req1 ADD 0+0 returns the pointer to req0
        req_valid = 2'b10; op[1] = 3'b000; a[1] = 16'h0000; b[1] = 16'h0000;
        step();
        chk("zadd_flags", 32'(flags), 32'b100);

        // Both requesting: alternate grants, no bubbles
        req_valid = 2'b11;
        op[0] = 3'b000; a[0] = 16'd1; b[0] = 16'd1;
        op[1] = 3'b000; a[1] = 16'd2; b[1] = 16'd2;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_ready", 32'(req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
            step();
            chk("rr_valid", 32'(res_valid), 32'd1);
            chk("rr_id",    32'(res_id),    32'(i % 2));
            chk("rr_data",  32'(res_data),  (i % 2 == 0) ? 32'd2 : 32'd4);
        end
        req_valid = 2'b00;
        chk("rr_flags", 32'(flags), 32'b000);

        // SUB 5-5 then backpressure
        req_valid = 2'b01; op[0] = 3'b001; a[0] = 16'd5; b[0] = 16'd5;
        step();
        res_ready = 1'b0;
        req_valid = 2'b11;
        op[0] = 3'b000; a[0] = 16'd3; b[0] = 16'd3;
        op[1] = 3'b000; a[1] = 16'd7; b[1] = 16'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_data",  32'(res_data),  32'd0);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_flags", 32'(flags),     32'b100);
            step();
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release", 32'(req_ready), 32'd2);
        step();
        req_valid = 2'b00;
        res_ready = 1'b0;
        chk("bp_data2",  32'(res_data), 32'd8);
        chk("bp_id2",    32'(res_id),   32'd1);
        chk("bp_flags2", 32'(flags),    32'b000);
        step();
        chk("hold_valid", 32'(res_valid), 32'd1);

        // Drain without issue empties the buffer
        res_ready = 1'b1;
        step();
        chk("drain_valid", 32'(res_valid), 32'd0);

        // Fill with a nonzero result and Z/N-visible flags, then reset mid-FULL
        req_valid = 2'b01; op[0] = 3'b001; a[0] = 16'd1; b[0] = 16'd2;
        step();
        req_valid = 2'b00;
        res_ready = 1'b0;
        chk("pre_rst_flags", 32'(flags), 32'b001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(res_valid), 32'd0);
        chk("arst_flags", 32'(flags),     32'd0);
        chk("arst_data",  32'(res_data),  32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        res_ready = 1'b1;
        req_valid = 2'b11;
        op[0] = 3'b000; a[0] = 16'd1; b[0] = 16'd1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 2'b00;
        chk("post_rst_id", 32'(res_id), 32'd0);

`ifdef ALU_ERR_STICKY_EN
        step();
        chk("stk_init", 32'(err_sticky), 32'd0);
        req_valid = 2'b01; op[0] = 3'b000; a[0] = 16'h7FFF; b[0] = 16'h0001;
        step();
        chk("stk_set", 32'(err_sticky), 32'd1);
        op[0] = 3'b001; a[0] = 16'd5; b[0] = 16'd5;
        step();
        req_valid = 2'b00;
        chk("stk_hold", 32'(err_sticky), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("stk_clr", 32'(err_sticky), 32'd0);
        req_valid = 2'b01; op[0] = 3'b000; a[0] = 16'h7FFF; b[0] = 16'h0001;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        req_valid = 2'b00;
        chk("stk_set_wins", 32'(err_sticky), 32'd1);
`endif

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
